// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: dispatch allocates at the tail, writeback marks entries ready, retire pops the head.
// Optional macro ROB_WB_BYPASS_EN forwards a same-cycle writeback to the head entry straight onto rob_head.
package reorder_buffer_pkg;
  localparam int ROB_DEPTH  = 16;
  localparam int ROB_TAG_W  = $clog2(ROB_DEPTH);
  localparam int ROB_DATA_W = 64;

  typedef struct packed {
    logic [4:0]            rd;
    logic [7:0]            ctrl_bits;
    logic                  ready;
    logic [ROB_TAG_W-1:0]  tag;
    logic [ROB_DATA_W-1:0] value;
  } rob_entry;
endpackage

module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int TAG_W  = $clog2(DEPTH),
  parameter int DATA_W = ROB_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_valid,
  input  rob_entry          alloc_entry,
  output logic [TAG_W-1:0]  alloc_tag,
  output logic              alloc_accept,
  output logic              rob_full,
  output logic              rob_empty,
  output logic [TAG_W:0]    count,
  input  logic              wb_valid,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic [DATA_W-1:0] wb_value,
  output rob_entry          rob_head,
  input  logic              rob_decrement,
  input  logic              flush
);

  rob_entry             entry_q [DEPTH];
  logic [DEPTH-1:0]     valid_q;
  logic [TAG_W-1:0]     head_q;
  logic [TAG_W-1:0]     tail_q;
  logic [TAG_W:0]       count_q;
  logic                 do_pop;
  logic                 wb_hit;
  rob_entry             head_view;
  rob_entry             new_entry;

  // Full/empty come from the occupancy count; head==tail is ambiguous.
  assign count        = count_q;
  assign rob_full     = (count_q == (TAG_W+1)'(DEPTH));
  assign rob_empty    = (count_q == '0);
  assign alloc_tag    = tail_q;
  assign alloc_accept = alloc_valid && !rob_full;

  always_comb begin
    head_view = valid_q[head_q] ? entry_q[head_q] : '0;
`ifdef ROB_WB_BYPASS_EN
    if (wb_valid && (wb_tag == head_q) && valid_q[head_q]) begin
      head_view.ready = 1'b1;
      head_view.value = wb_value;
    end
`endif
  end

  assign rob_head = head_view;

  // Only ready heads retire; a writeback racing with the pop of its own slot is dropped.
  assign do_pop = rob_decrement && !rob_empty && head_view.ready;
  assign wb_hit = wb_valid && valid_q[wb_tag] && !(do_pop && (wb_tag == head_q));

  always_comb begin
    new_entry       = alloc_entry;
    new_entry.tag   = tail_q;
    new_entry.ready = 1'b0;
    new_entry.value = '0;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      if (wb_hit) begin
        entry_q[wb_tag].value <= wb_value;
        entry_q[wb_tag].ready <= 1'b1;
      end
      // Allocation is written after writeback so it wins on the tail slot.
      if (alloc_accept) begin
        entry_q[tail_q] <= new_entry;
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + TAG_W'(1);
      end
      if (do_pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + TAG_W'(1);
      end
      case ({alloc_accept, do_pop})
        2'b10:   count_q <= count_q + (TAG_W+1)'(1);
        2'b01:   count_q <= count_q - (TAG_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: queue-based reference model compared every cycle,
// plus directed sequences with hand-computed expectations.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int DEPTH = 16;
`ifdef ROB_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        alloc_valid;
  rob_entry    alloc_entry;
  logic [3:0]  alloc_tag;
  logic        alloc_accept;
  logic        rob_full;
  logic        rob_empty;
  logic [4:0]  count;
  logic        wb_valid;
  logic [3:0]  wb_tag;
  logic [63:0] wb_value;
  rob_entry    rob_head;
  logic        rob_decrement;
  logic        flush;

  int assertions = 0;
  int failures   = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [7:0]  ctrl;
    logic        ready;
    logic [63:0] value;
  } mentry_t;

  mentry_t  mq[$];
  int       mbase = 0;
  bit       model_ok = 1'b0;
  rob_entry mh;
  int       widx;
  bit       mpop;
  mentry_t  mnew;

  reorder_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .alloc_valid  (alloc_valid),
    .alloc_entry  (alloc_entry),
    .alloc_tag    (alloc_tag),
    .alloc_accept (alloc_accept),
    .rob_full     (rob_full),
    .rob_empty    (rob_empty),
    .count        (count),
    .wb_valid     (wb_valid),
    .wb_tag       (wb_tag),
    .wb_value     (wb_value),
    .rob_head     (rob_head),
    .rob_decrement(rob_decrement),
    .flush        (flush)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Oldest model entry as it must appear on rob_head given the current inputs.
  function automatic rob_entry expHead();
    rob_entry e;
    e = '0;
    if (mq.size() > 0) begin
      e.rd        = mq[0].rd;
      e.ctrl_bits = mq[0].ctrl;
      e.tag       = 4'(mbase);
      e.ready     = mq[0].ready;
      e.value     = mq[0].value;
      if (BYP && wb_valid && (int'(wb_tag) == mbase)) begin
        e.ready = 1'b1;
        e.value = wb_value;
      end
    end
    return e;
  endfunction

  always @(posedge clk) begin
    if (reset || flush) begin
      mq.delete();
      mbase    = 0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      mh   = expHead();
      mpop = rob_decrement && (mq.size() > 0) && mh.ready;
      if (wb_valid) begin
        widx = (int'(wb_tag) - mbase + DEPTH) % DEPTH;
        if (widx < mq.size() && !(mpop && widx == 0)) begin
          mq[widx].ready = 1'b1;
          mq[widx].value = wb_value;
        end
      end
      if (alloc_valid && mq.size() < DEPTH) begin
        mnew.rd    = alloc_entry.rd;
        mnew.ctrl  = alloc_entry.ctrl_bits;
        mnew.ready = 1'b0;
        mnew.value = '0;
        mq.push_back(mnew);
      end
      if (mpop) begin
        void'(mq.pop_front());
        mbase = (mbase + 1) % DEPTH;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok && !reset) begin
      checkOutput("count",        128'(count),        128'(mq.size()));
      checkOutput("rob_full",     128'(rob_full),     128'(mq.size() == DEPTH));
      checkOutput("rob_empty",    128'(rob_empty),    128'(mq.size() == 0));
      checkOutput("alloc_tag",    128'(alloc_tag),    128'((mbase + mq.size()) % DEPTH));
      checkOutput("alloc_accept", 128'(alloc_accept), 128'(alloc_valid && mq.size() < DEPTH));
      checkOutput("rob_head",     128'(rob_head),     128'(expHead()));
    end
  end

  task automatic applyStimulus(input bit av, input int rd, input bit wbv, input int wbt,
                               input logic [63:0] wbval, input bit dec, input bit fl);
    alloc_valid           = av;
    alloc_entry           = '0;
    alloc_entry.rd        = 5'(rd);
    alloc_entry.ctrl_bits = 8'(rd * 3 + 1);
    alloc_entry.ready     = 1'b1;
    alloc_entry.tag       = 4'(rd + 7);
    alloc_entry.value     = 64'hDEAD_BEEF_0000_0000 | 64'(rd);
    wb_valid              = wbv;
    wb_tag                = 4'(wbt);
    wb_value              = wbval;
    rob_decrement         = dec;
    flush                 = fl;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 64'h0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    settle();
    checkOutput("reset_empty", 128'(rob_empty), 128'(1));
    checkOutput("reset_full",  128'(rob_full),  128'(0));
    checkOutput("reset_tag",   128'(alloc_tag), 128'(0));
    checkOutput("reset_head",  128'(rob_head),  128'(0));
    checkOutput("reset_count", 128'(count),     128'(0));

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, i + 1, 0, 0, 64'h0, 0, 0);
      settle();
      checkOutput("alloc3_tag", 128'(alloc_tag), 128'(i));
      checkOutput("alloc3_acc", 128'(alloc_accept), 128'(1));
      tick();
    end
    idle();
    settle();
    checkOutput("alloc3_count", 128'(count), 128'(3));
    checkOutput("alloc3_htag",  128'(rob_head.tag), 128'(0));
    checkOutput("alloc3_hrdy",  128'(rob_head.ready), 128'(0));
    checkOutput("alloc3_hrd",   128'(rob_head.rd), 128'(1));

    applyStimulus(0, 0, 1, 1, 64'hAA, 0, 0);
    tick();
    applyStimulus(0, 0, 1, 0, 64'h55, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 64'h0, 1, 0);
    settle();
    checkOutput("pop1_value", 128'(rob_head.value), 128'(64'h55));
    checkOutput("pop1_rd",    128'(rob_head.rd), 128'(1));
    tick();
    applyStimulus(0, 0, 0, 0, 64'h0, 1, 0);
    settle();
    checkOutput("pop2_value", 128'(rob_head.value), 128'(64'hAA));
    checkOutput("pop2_rd",    128'(rob_head.rd), 128'(2));
    tick();
    idle();
    settle();
    checkOutput("pop_count", 128'(count), 128'(1));

    applyStimulus(0, 0, 0, 0, 64'h0, 0, 1);
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1, i, 0, 0, 64'h0, 0, 0);
      tick();
    end
    idle();
    settle();
    checkOutput("fill_full",  128'(rob_full), 128'(1));
    checkOutput("fill_count", 128'(count), 128'(16));
    applyStimulus(1, 9, 0, 0, 64'h0, 0, 0);
    settle();
    checkOutput("fill_17th_acc", 128'(alloc_accept), 128'(0));
    tick();
    applyStimulus(0, 0, 1, 0, 64'h1, 0, 0);
    tick();
    applyStimulus(1, 9, 0, 0, 64'h0, 1, 0);
    settle();
    checkOutput("full_popalloc_acc", 128'(alloc_accept), 128'(0));
    tick();
    idle();
    settle();
    checkOutput("full_popalloc_count", 128'(count), 128'(15));
    checkOutput("full_popalloc_full",  128'(rob_full), 128'(0));

    applyStimulus(0, 0, 0, 0, 64'h0, 0, 1);
    tick();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, i, 0, 0, 64'h0, 0, 0);
      settle();
      checkOutput("wrap_alloc_tag", 128'(alloc_tag), 128'(i % 16));
      tick();
      applyStimulus(0, 0, 1, i % 16, 64'(i + 100), 0, 0);
      settle();
      checkOutput("wrap_head_tag", 128'(rob_head.tag), 128'(i % 16));
      tick();
      applyStimulus(0, 0, 0, 0, 64'h0, 1, 0);
      settle();
      checkOutput("wrap_pop_value", 128'(rob_head.value), 128'(i + 100));
      tick();
    end
    idle();
    settle();
    checkOutput("wrap_empty", 128'(rob_empty), 128'(1));

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, i + 4, 0, 0, 64'h0, 0, 0);
      tick();
    end
    applyStimulus(1, 30, 1, 2, 64'h1234, 0, 1);
    tick();
    idle();
    settle();
    checkOutput("flush_count", 128'(count), 128'(0));
    checkOutput("flush_empty", 128'(rob_empty), 128'(1));
    checkOutput("flush_tag",   128'(alloc_tag), 128'(0));
    checkOutput("flush_head",  128'(rob_head), 128'(0));

    applyStimulus(1, 11, 0, 0, 64'h0, 0, 0);
    tick();
    applyStimulus(0, 0, 1, 0, 64'h7, 0, 0);
    settle();
    checkOutput("byp_same_ready", 128'(rob_head.ready), 128'(BYP));
    checkOutput("byp_same_value", 128'(rob_head.value), 128'(BYP ? 64'h7 : 64'h0));
    tick();
    idle();
    settle();
    checkOutput("byp_next_ready", 128'(rob_head.ready), 128'(1));
    checkOutput("byp_next_value", 128'(rob_head.value), 128'(64'h7));

    applyStimulus(0, 0, 0, 0, 64'h0, 0, 1);
    tick();
    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom_range(0, 99) < 55, int'($urandom_range(0, 31)),
                    $urandom_range(0, 99) < 50, int'($urandom_range(0, 15)),
                    {$urandom, $urandom}, $urandom_range(0, 99) < 50,
                    $urandom_range(0, 199) == 0);
      tick();
    end
    idle();
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
